// File: rtl/posit_norm_round_pipe_if.sv
// ============================================================================
// Module : posit_norm_round_pipe_if
// Brief  : Valid/ready bundle between the add/sub core, the posit
//          normalise/round pipe and its consumer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface posit_norm_round_pipe_if #(
    parameter int N         = 16,
    parameter int ES        = 1,
    parameter int TE_SIZE   = ES + $clog2(N) + 1,
    parameter int MANT_SIZE = N
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     sign_in;
    logic                     is_zero_in;
    logic                     is_nar_in;
    logic [TE_SIZE-1:0]       te_in;
    logic [2*MANT_SIZE-1:0]   mant_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [N-1:0]             posit_out;
    logic                     inexact;

    // Producer/consumer side (drives the beat, accepts the result)
    modport master (
        output in_valid, sign_in, is_zero_in, is_nar_in, te_in, mant_in, out_ready,
        input  in_ready, out_valid, posit_out, inexact
    );

    // Pipe side
    modport slave (
        input  in_valid, sign_in, is_zero_in, is_nar_in, te_in, mant_in, out_ready,
        output in_ready, out_valid, posit_out, inexact
    );
endinterface

`default_nettype wire

// File: rtl/posit_norm_round_pipe.sv
// ============================================================================
// Module : posit_norm_round_pipe
// Brief  : 3-stage posit normalise / regime build / RNE round / negate pipe.
// Config : define PPU_INEXACT_CNT_EN to add the saturating inexact_cnt output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_norm_round_pipe #(
    parameter int N         = 16,
    parameter int ES        = 1,
    parameter int TE_SIZE   = ES + $clog2(N) + 1,
    parameter int MANT_SIZE = N
) (
    input  wire                       clk,
    input  wire                       rst,
    posit_norm_round_pipe_if.slave    pipe
`ifdef PPU_INEXACT_CNT_EN
    ,
    output logic [31:0]               inexact_cnt
`endif
);

    localparam int c_mw    = 2 * MANT_SIZE;
    localparam int c_lzc_w = $clog2(c_mw) + 1;
    // Wide enough that te + 1 - lzc can never wrap for any legal input.
    localparam int c_te_w  = TE_SIZE + c_lzc_w + 1;
    localparam int c_fw    = 2 + ES + (c_mw - 1) + N;

    localparam logic [N-1:0]              c_maxpos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]              c_minpos = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]              c_nar    = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [c_te_w-1:0]  c_te_one = c_te_w'(1);
    localparam logic signed [c_te_w-1:0]  c_k_max  = c_te_w'(N - 2);
    localparam logic signed [c_te_w-1:0]  c_k_min  = c_te_w'(-(N - 1));

    // ------------------------------------------------------------------
    // Handshake: a stage advances when empty or when its successor does
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid, r_s3_valid;
    logic w_s1_en, w_s2_en, w_s3_en;

    assign w_s3_en = !r_s3_valid || pipe.out_ready;
    assign w_s2_en = !r_s2_valid || w_s3_en;
    assign w_s1_en = !r_s1_valid || w_s2_en;

    assign pipe.in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // Stage 1: leading-one detect and normalise
    // ------------------------------------------------------------------
    logic [c_lzc_w-1:0]       w_lzc;
    logic [c_mw-1:0]          w_mant_norm;
    logic signed [c_te_w-1:0] w_te_ext;
    logic signed [c_te_w-1:0] w_lzc_ext;
    logic signed [c_te_w-1:0] w_te_norm;

    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < c_mw; i++) begin
            if (pipe.mant_in[i]) begin
                w_lzc = c_lzc_w'(c_mw - 1 - i);
            end
        end
    end

    assign w_mant_norm = pipe.mant_in << w_lzc;
    assign w_te_ext    = {{(c_te_w-TE_SIZE){pipe.te_in[TE_SIZE-1]}}, pipe.te_in};
    assign w_lzc_ext   = {{(c_te_w-c_lzc_w){1'b0}}, w_lzc};
    assign w_te_norm   = w_te_ext + c_te_one - w_lzc_ext;

    logic                     r_s1_sign, r_s1_zero, r_s1_nar;
    logic signed [c_te_w-1:0] r_s1_te;
    logic [c_mw-1:0]          r_s1_mant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s1_te    <= '0;
            r_s1_mant  <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= pipe.in_valid;
            if (pipe.in_valid) begin
                r_s1_sign <= pipe.sign_in;
                r_s1_zero <= pipe.is_zero_in;
                r_s1_nar  <= pipe.is_nar_in;
                r_s1_te   <= w_te_norm;
                r_s1_mant <= w_mant_norm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: regime/exponent/fraction packing and RNE rounding
    // ------------------------------------------------------------------
    logic signed [c_te_w-1:0] w_k;
    logic [ES-1:0]            w_exp;
    logic [c_te_w-1:0]        w_sh;
    logic [c_fw-1:0]          w_field_in;
    logic [c_fw-1:0]          w_field;
    logic [N-1:0]             w_mag_t;
    logic [N-1:0]             w_mag_r;
    logic                     w_guard, w_sticky, w_rnd;
    logic [N-1:0]             w_mag;
    logic                     w_inx;
    logic                     w_s2_zero;

    assign w_k   = r_s1_te >>> ES;
    assign w_exp = r_s1_te[ES-1:0];
    // Negative k needs -k zeros before the terminating 1; ~k == -k-1 shifts.
    assign w_sh  = w_k[c_te_w-1] ? ~w_k : w_k;
    assign w_field_in = {(w_k[c_te_w-1] ? 2'b01 : 2'b10), w_exp,
                         r_s1_mant[c_mw-2:0], {N{1'b0}}};

    always_comb begin
        w_field = w_field_in >> w_sh;
        if (!w_k[c_te_w-1]) begin
            w_field = $signed(w_field_in) >>> w_sh;
        end
    end

    assign w_mag_t  = {1'b0, w_field[c_fw-1 -: N-1]};
    assign w_guard  = w_field[c_fw-N];
    assign w_sticky = |w_field[c_fw-N-1:0];
    assign w_rnd    = w_guard && (w_sticky || w_mag_t[0]);
    assign w_mag_r  = w_mag_t + {{(N-1){1'b0}}, w_rnd};
    // Normalised mantissa lacking its hidden bit means mant_in was zero.
    assign w_s2_zero = r_s1_zero || !r_s1_mant[c_mw-1];

    always_comb begin
        w_mag = w_mag_r[N-1] ? c_maxpos : w_mag_r;
        w_inx = w_guard || w_sticky;
        if (w_k >= c_k_max) begin
            w_mag = c_maxpos;
            w_inx = 1'b1;
        end else if (w_k <= c_k_min) begin
            w_mag = c_minpos;
            w_inx = 1'b1;
        end
    end

    logic         r_s2_sign, r_s2_zero, r_s2_nar, r_s2_inexact;
    logic [N-1:0] r_s2_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_sign    <= 1'b0;
            r_s2_zero    <= 1'b0;
            r_s2_nar     <= 1'b0;
            r_s2_inexact <= 1'b0;
            r_s2_mag     <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign    <= r_s1_sign;
                r_s2_zero    <= w_s2_zero;
                r_s2_nar     <= r_s1_nar;
                r_s2_inexact <= w_inx;
                r_s2_mag     <= w_mag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sign application and special-value override
    // ------------------------------------------------------------------
    logic [N-1:0] w_posit;
    logic         w_s3_inx;

    always_comb begin
        w_posit  = r_s2_sign ? (~r_s2_mag + c_minpos) : r_s2_mag;
        w_s3_inx = r_s2_inexact;
        if (r_s2_nar) begin
            w_posit  = c_nar;
            w_s3_inx = 1'b0;
        end else if (r_s2_zero) begin
            w_posit  = '0;
            w_s3_inx = 1'b0;
        end
    end

    logic [N-1:0] r_s3_posit;
    logic         r_s3_inexact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid   <= 1'b0;
            r_s3_posit   <= '0;
            r_s3_inexact <= 1'b0;
        end else if (w_s3_en) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_posit   <= w_posit;
                r_s3_inexact <= w_s3_inx;
            end
        end
    end

    assign pipe.out_valid = r_s3_valid;
    assign pipe.posit_out = r_s3_posit;
    assign pipe.inexact   = r_s3_inexact;

`ifdef PPU_INEXACT_CNT_EN
    logic [31:0] r_inexact_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inexact_cnt <= '0;
        end else if (r_s3_valid && pipe.out_ready && r_s3_inexact
                     && (r_inexact_cnt != 32'hFFFF_FFFF)) begin
            r_inexact_cnt <= r_inexact_cnt + 32'd1;
        end
    end

    assign inexact_cnt = r_inexact_cnt;
`endif

endmodule

`default_nettype wire
